// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional atomic lock feature is enabled with MEM_ARB_ATOMIC_EN.
package mem_arbiter_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam logic [2:0]  IF_F3_DEF = 3'b010;

  // One-hot grant encoding: bit 0 instruction side, bit 1 data side
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10,
    ST_RESP   = 2'b11
  } arb_state_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == ST_BUSY_I) || (s == ST_BUSY_D);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin pick between instruction and data requests,
// with a lock input that restricts grants to the data side.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       req_i_i,
  input  logic       req_d_i,
  input  logic       last_data_i,
  input  logic       lock_i,
  output logic [1:0] grant_o
);

  // Lock wins over fairness; a tie goes to the side that did not win last
  always_comb begin
    grant_o = GNT_NONE;
    if (lock_i) begin
      if (req_d_i) begin
        grant_o = GNT_D;
      end else begin
        grant_o = GNT_NONE;
      end
    end else if (req_i_i && req_d_i) begin
      if (last_data_i) begin
        grant_o = GNT_I;
      end else begin
        grant_o = GNT_D;
      end
    end else if (req_i_i) begin
      grant_o = GNT_I;
    end else if (req_d_i) begin
      grant_o = GNT_D;
    end else begin
      grant_o = GNT_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and data-memory accesses onto one memory port.
// Define MEM_ARB_ATOMIC_EN to add i_DM_atomic and the data-side bus lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN          = XLEN_DEF,
  parameter logic [2:0]  IF_F3         = IF_F3_DEF,
  parameter logic        RST_LAST_DATA = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic            o_IC_MemReady,
  output logic [XLEN-1:0] o_IC_DataBlock,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
`ifdef MEM_ARB_ATOMIC_EN
  input  logic            i_DM_atomic,
`endif
  output logic            o_MEM_req,
  output logic            o_MEM_we,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wdata,
  output logic [2:0]      o_MEM_f3,
  input  logic            i_MEM_ready,
  input  logic [XLEN-1:0] i_MEM_rdata
);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            side_q, side_d;
  logic [XLEN-1:0] resp_q, resp_d;

  logic            dm_req_s;
  logic            lock_s;
  logic [1:0]      grant_s;
  logic            ic_rdy_s;
  logic            dm_rdy_s;

  assign dm_req_s = i_DM_Wen | i_DM_MemRead;

`ifdef MEM_ARB_ATOMIC_EN
  logic lock_q, lock_d;

  // Lock only blocks refills while the atomic sequence is still flagged
  assign lock_s = lock_q & i_DM_atomic;

  // Lock is set by an atomic data grant and released in IDLE once atomic drops
  always_comb begin
    lock_d = lock_q;
    if (state_q == ST_IDLE) begin
      if ((grant_s == GNT_D) && i_DM_atomic) begin
        lock_d = 1'b1;
      end else if (!i_DM_atomic) begin
        lock_d = 1'b0;
      end else begin
        lock_d = lock_q;
      end
    end else begin
      lock_d = lock_q;
    end
  end

  // Lock register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign lock_s = 1'b0;
`endif

  mem_arb_pick u_pick (
    .req_i_i     (i_IC_DataReq),
    .req_d_i     (dm_req_s),
    .last_data_i (last_q),
    .lock_i      (lock_s),
    .grant_o     (grant_s)
  );

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= RST_LAST_DATA;
      we_q    <= 1'b0;
      addr_q  <= {XLEN{1'b0}};
      wdata_q <= {XLEN{1'b0}};
      f3_q    <= 3'b000;
      side_q  <= 1'b0;
      resp_q  <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      side_q  <= side_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state and capture logic; memory regs only change on a grant
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    side_d  = side_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s == GNT_I) begin
          state_d = ST_BUSY_I;
          last_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = i_IC_Addr;
          wdata_d = {XLEN{1'b0}};
          f3_d    = IF_F3;
        end else if (grant_s == GNT_D) begin
          state_d = ST_BUSY_D;
          last_d  = 1'b1;
          we_d    = i_DM_Wen;
          addr_d  = i_DM_Addr;
          wdata_d = i_DM_Wd;
          f3_d    = i_DM_f3;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (i_MEM_ready) begin
          resp_d  = i_MEM_rdata;
          side_d  = (state_q == ST_BUSY_D);
          state_d = ST_RESP;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state
  always_comb begin
    o_MEM_req = is_busy(state_q);
    ic_rdy_s  = 1'b0;
    dm_rdy_s  = 1'b0;
    case (state_q)
      ST_RESP: begin
        if (side_q) begin
          dm_rdy_s = 1'b1;
        end else begin
          ic_rdy_s = 1'b1;
        end
      end
      default: begin
        ic_rdy_s = 1'b0;
        dm_rdy_s = 1'b0;
      end
    endcase
  end

  assign o_MEM_we        = we_q;
  assign o_MEM_addr      = addr_q;
  assign o_MEM_wdata     = wdata_q;
  assign o_MEM_f3        = f3_q;
  assign o_IC_MemReady   = ic_rdy_s;
  assign o_DM_data_ready = dm_rdy_s;
  assign o_IC_DataBlock  = ic_rdy_s ? resp_q : {XLEN{1'b0}};
  assign o_DM_ReadData   = dm_rdy_s ? resp_q : {XLEN{1'b0}};

endmodule
